// File: rtl/stride_decimator_2d.sv
// Streaming 2-D spatial stride for a raster-order, channel-interleaved pixel stream.
// Keeps pixels on stride-aligned rows/columns and flags the end of each output row and frame.
module stride_decimator_2d #(
    parameter int IMG_WIDTH  = 299,
    parameter int IMG_HEIGHT = 299,
    parameter int STRIDE_W   = 2,
    parameter int STRIDE_H   = 2,
    parameter int CHANNELS   = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Valid_Out,
    output logic                  Row_Last,
    output logic                  Frame_Done
);

    localparam int CH_W  = (CHANNELS   > 1) ? $clog2(CHANNELS)   : 1;
    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int CPH_W = (STRIDE_W   > 1) ? $clog2(STRIDE_W)   : 1;
    localparam int RPH_W = (STRIDE_H   > 1) ? $clog2(STRIDE_H)   : 1;

    localparam int OUT_W = (IMG_WIDTH  + STRIDE_W - 1) / STRIDE_W;
    localparam int OUT_H = (IMG_HEIGHT + STRIDE_H - 1) / STRIDE_H;

    localparam logic [CH_W-1:0]  CH_END       = CH_W'(CHANNELS - 1);
    localparam logic [COL_W-1:0] COL_END      = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_END      = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [CPH_W-1:0] CPH_END      = CPH_W'(STRIDE_W - 1);
    localparam logic [RPH_W-1:0] RPH_END      = RPH_W'(STRIDE_H - 1);
    // Last column/row that survives decimation; the remainder of a partial stride group is dropped.
    localparam logic [COL_W-1:0] COL_KEEP_END = COL_W'((OUT_W - 1) * STRIDE_W);
    localparam logic [ROW_W-1:0] ROW_KEEP_END = ROW_W'((OUT_H - 1) * STRIDE_H);

    logic [CH_W-1:0]  ch_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [CPH_W-1:0] col_ph;
    logic [RPH_W-1:0] row_ph;

    logic ch_wrap;
    logic col_wrap;
    logic row_wrap;
    logic keep;
    logic take;
    logic row_end_hit;

    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;
    logic                  row_last_p1;
    logic                  frame_done_p1;

    assign ch_wrap     = (ch_cnt == CH_END);
    assign col_wrap    = (col_cnt == COL_END);
    assign row_wrap    = (row_cnt == ROW_END);
    assign keep        = (col_ph == '0) && (row_ph == '0);
    assign take        = Valid_In && keep;
    assign row_end_hit = take && ch_wrap && (col_cnt == COL_KEEP_END);

    // Stage p0: position counters, advanced only by accepted words
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_cnt  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            col_ph  <= '0;
            row_ph  <= '0;
        end else if (Valid_In) begin
            if (!ch_wrap) begin
                ch_cnt <= ch_cnt + CH_W'(1);
            end else begin
                ch_cnt <= '0;
                if (!col_wrap) begin
                    col_cnt <= col_cnt + COL_W'(1);
                    col_ph  <= (col_ph == CPH_END) ? '0 : col_ph + CPH_W'(1);
                end else begin
                    col_cnt <= '0;
                    col_ph  <= '0;
                    if (!row_wrap) begin
                        row_cnt <= row_cnt + ROW_W'(1);
                        row_ph  <= (row_ph == RPH_END) ? '0 : row_ph + RPH_W'(1);
                    end else begin
                        row_cnt <= '0;
                        row_ph  <= '0;
                    end
                end
            end
        end
    end

    // Stage p1: registered output word and its framing flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_p1       <= '0;
            vld_p1        <= 1'b0;
            row_last_p1   <= 1'b0;
            frame_done_p1 <= 1'b0;
        end else begin
            vld_p1        <= take;
            row_last_p1   <= row_end_hit;
            frame_done_p1 <= row_end_hit && (row_cnt == ROW_KEEP_END);
            if (take) begin
                data_p1 <= Data_In;
            end
        end
    end

    assign Data_Out   = data_p1;
    assign Valid_Out  = vld_p1;
    assign Row_Last   = row_last_p1;
    assign Frame_Done = frame_done_p1;

endmodule

// File: tb/tb_stride_decimator_2d.sv
// Scoreboard bench for stride_decimator_2d over three geometries, each with its own DUT,
// stimulus process and monitor; expectations come from pixel-index arithmetic.
module tb_stride_decimator_2d;

    typedef struct {
        logic [31:0] d;
        bit          rl;
        bit          fd;
        int          due;
    } exp_t;

    logic clk;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    bit   done [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int id, input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL cfg%0d %s: got %0h expected %0h (cycle %0d)", id, nm, act, req, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W  = (g == 0) ? 6 : (g == 1) ? 5 : 3;
        localparam int H  = (g == 0) ? 4 : (g == 1) ? 3 : 2;
        localparam int SW = (g == 2) ? 1 : 2;
        localparam int SH = (g == 2) ? 1 : 2;
        localparam int CH = (g == 1) ? 3 : 1;
        localparam int FW = W * H * CH;

        logic        rst;
        logic [31:0] din;
        logic        vin;
        logic [31:0] dout;
        logic        vout;
        logic        rl;
        logic        fd;

        exp_t        q[$];
        int          pos;
        logic [31:0] last_d;

        stride_decimator_2d #(
            .IMG_WIDTH (W),
            .IMG_HEIGHT(H),
            .STRIDE_W  (SW),
            .STRIDE_H  (SH),
            .CHANNELS  (CH),
            .DATA_WIDTH(32)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .Data_In   (din),
            .Valid_In  (vin),
            .Data_Out  (dout),
            .Valid_Out (vout),
            .Row_Last  (rl),
            .Frame_Done(fd)
        );

        // Reference: word index -> (row, col, channel); keep stride-aligned pixels.
        task automatic send(input logic [31:0] d);
            int   pix, c, r, col;
            exp_t e;
            @(posedge clk);
            #1;
            vin = 1'b1;
            din = d;
            pix = pos / CH;
            c   = pos % CH;
            r   = pix / W;
            col = pix % W;
            if ((r % SH == 0) && (col % SW == 0)) begin
                e.d   = d;
                e.rl  = (c == CH - 1) && (col == ((W - 1) / SW) * SW);
                e.fd  = e.rl && (r == ((H - 1) / SH) * SH);
                e.due = cyc + 1;
                q.push_back(e);
            end
            pos = (pos + 1) % FW;
        endtask

        task automatic idle();
            @(posedge clk);
            #1;
            vin = 1'b0;
            din = $urandom;
        endtask

        task automatic rand_traffic(input int n);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) != 0) send($urandom);
                else idle();
            end
        endtask

        initial begin
            rst = 1'b0;
            vin = 1'b0;
            din = '0;
            pos = 0;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b1;
            if (g == 0) begin
                for (int i = 0; i < 24; i++) send(i);
                for (int i = 0; i < 24; i++) send(100 + i);
                for (int i = 0; i < 24; i++) begin
                    send(i);
                    idle();
                end
                for (int i = 0; i < 10; i++) send(i);
                idle();
                @(posedge clk);
                #1;
                rst = 1'b0;
                q.delete();
                pos = 0;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                for (int i = 0; i < 24; i++) send(i);
            end else if (g == 1) begin
                for (int i = 0; i < 45; i++) send(i);
            end else begin
                for (int i = 0; i < 6; i++) send(i);
            end
            rand_traffic(6 * FW);
            repeat (4) idle();
            check(g, "drain", q.size(), 0);
            done[g] = 1'b1;
        end

        initial begin
            exp_t e;
            last_d = '0;
            forever begin
                @(negedge clk);
                if (rst !== 1'b1) begin
                    check(g, "rst_dout", dout, 0);
                    check(g, "rst_vout", vout, 0);
                    check(g, "rst_rl", rl, 0);
                    check(g, "rst_fd", fd, 0);
                    last_d = '0;
                end else if (vout === 1'b1) begin
                    if (q.size() == 0) begin
                        check(g, "unexpected_vout", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check(g, "data", dout, e.d);
                        check(g, "row_last", rl, e.rl);
                        check(g, "frame_done", fd, e.fd);
                        check(g, "latency", cyc, e.due);
                    end
                    last_d = dout;
                end else begin
                    check(g, "hold", dout, last_d);
                    check(g, "idle_rl", rl, 0);
                    check(g, "idle_fd", fd, 0);
                    if (q.size() > 0 && q[0].due <= cyc) begin
                        check(g, "missing_vout", 0, 1);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk);
            if (done[0] && done[1] && done[2]) break;
        end
        if (!(done[0] && done[1] && done[2])) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got done=%0b%0b%0b expected 111", done[2], done[1], done[0]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
